// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, state type and helpers
// for the load/store split unit.
package lsu_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    SECOND,
    RESP
  } lsu_state_t;

  // access size in bytes: 1, 2 or 4
  function automatic logic [2:0] size_of(
    input logic [2:0] f3
  );
    logic [2:0] s;
    unique case (f3[1:0])
      2'b00:   s = 3'd1;
      2'b01:   s = 3'd2;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

  // unshifted lane mask, 8 bits wide
  function automatic logic [7:0] lane_mask(
    input logic [2:0] f3
  );
    logic [7:0] m;
    unique case (f3[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of a right-justified
// load value of 1, 2 or 4 bytes.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [WIDTH-1:0] raw,
  input  logic [2:0]       size,
  input  logic             uns,
  output logic [WIDTH-1:0] res
);

  logic sb;
  logic sh;

  assign sb = ~uns & raw[7];
  assign sh = ~uns & raw[15];

  // pick the extension by access size
  always_comb begin
    res = raw;
    unique case (1'b1)
      size == 3'd1: res = {{24{sb}}, raw[7:0]};
      size == 3'd2: res = {{16{sh}}, raw[15:0]};
      default:      res = raw;
    endcase
  end

endmodule

// File: rtl/lsu_split.sv
// lsu_split: MEM-stage load/store unit; splits accesses
// that cross a word boundary into two bus transactions.
module lsu_split
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             bus_read,
  output logic             bus_write,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic [3:0]       bus_byteen,
  input  logic [WIDTH-1:0] bus_rdata
);

  lsu_state_t state_q, state_d;

  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hold_q,  hold_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  mask_q,  mask_d;
  logic [1:0]  off_q,   off_d;
  logic [2:0]  f3_q,    f3_d;
  logic        write_q, write_d;
  logic        err_q,   err_d;

  logic        accept;
  logic        illegal;
  logic        split;
  logic [7:0]  m8;
  logic [4:0]  sh1;
  logic [4:0]  sh2;
  logic [31:0] word1;
  logic [31:0] ext_raw;
  logic [2:0]  ext_size;
  logic        ext_uns;
  logic [31:0] ext_res;

  assign accept  = req_valid & req_ready;
  assign m8      = lane_mask(req_funct3) << req_addr[1:0];
  assign split   = |m8[7:4];
  assign sh1     = {req_addr[1:0], 3'b000};
  assign sh2     = 5'd0 - {off_q, 3'b000};
  assign word1   = {req_addr[31:2], 2'b00};
  assign illegal = !((req_funct3 inside {F3_LB, F3_LH, F3_LW})
                  || (!req_write
                      && (req_funct3 inside {F3_LBU, F3_LHU})));

  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

  // raw load bytes: direct word or hold plus second word
  always_comb begin
    ext_raw  = bus_rdata >> sh1;
    ext_size = size_of(req_funct3);
    ext_uns  = req_funct3[2];
    if (state_q == SECOND) begin
      ext_raw  = hold_q | (bus_rdata << sh2);
      ext_size = size_of(f3_q);
      ext_uns  = f3_q[2];
    end
  end

  lsu_extend u_ext (
    .raw  (ext_raw),
    .size (ext_size),
    .uns  (ext_uns),
    .res  (ext_res)
  );

  // next state, latches and bus drive
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    rdata_d    = rdata_q;
    mask_d     = mask_q;
    off_d      = off_q;
    f3_d       = f3_q;
    write_d    = write_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    bus_read   = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_byteen = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept && illegal) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (accept) begin
          bus_read   = !req_write;
          bus_write  = req_write;
          bus_addr   = word1;
          bus_byteen = m8[3:0];
          if (req_write)
            bus_wdata = req_wdata << sh1;
          err_d = 1'b0;
          if (split) begin
            state_d = SECOND;
            addr_d  = word1 + 32'd4;
            wdata_d = req_wdata;
            mask_d  = m8[7:4];
            off_d   = req_addr[1:0];
            f3_d    = req_funct3;
            write_d = req_write;
            hold_d  = req_write ? '0
                    : (bus_rdata >> sh1);
          end else begin
            state_d = RESP;
            rdata_d = req_write ? '0 : ext_res;
          end
        end
      end
      SECOND: begin
        bus_read   = !write_q;
        bus_write  = write_q;
        bus_addr   = addr_q;
        bus_byteen = mask_q;
        if (write_q)
          bus_wdata = wdata_q >> sh2;
        state_d = RESP;
        rdata_d = write_q ? '0 : ext_res;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
        err_d      = 1'b0;
        rdata_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and latch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// tb_lsu_split: directed checks of lsu_split against a
// small byte-lane memory.
module tb_lsu_split;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_rdata;

  logic [31:0] mem [256];
  int tests;
  int fails;

  lsu_split #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .bus_read   (bus_read),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byteen (bus_byteen),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_rdata = mem[bus_addr[9:2]];

  always @(posedge clk) begin
    if (bus_write) begin
      for (int i = 0; i < 4; i++)
        if (bus_byteen[i])
          mem[bus_addr[9:2]][8*i +: 8] = bus_wdata[8*i +: 8];
    end
  end

  task automatic issue(input logic w, input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0300;
    req_wdata  = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0
        || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_hs got rdy=%b v=%b e=%b exp 1 0 0",
               req_ready, resp_valid, resp_err);
    end
    tests++;
    if (resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_rdata got %h exp 0", resp_rdata);
    end
    tests++;
    if (bus_read !== 1'b0 || bus_write !== 1'b0
        || bus_byteen !== 4'h0) begin
      fails++;
      $display("FAIL rst_bus got r=%b w=%b be=%h exp 0 0 0",
               bus_read, bus_write, bus_byteen);
    end
    tests++;
    if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_bus_data got a=%h d=%h exp 0 0",
               bus_addr, bus_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lw;
    mem[8'h40] = 32'hDEAD_BEEF;
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    tests++;
    if (bus_read !== 1'b1 || bus_write !== 1'b0) begin
      fails++;
      $display("FAIL lw_strobe got r=%b w=%b exp 1 0",
               bus_read, bus_write);
    end
    tests++;
    if (bus_byteen !== 4'hF || bus_addr !== 32'h100) begin
      fails++;
      $display("FAIL lw_bus got be=%h a=%h exp f 100",
               bus_byteen, bus_addr);
    end
    step();
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF
        || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL lw_resp got v=%b d=%h e=%b exp 1 deadbeef 0",
               resp_valid, resp_rdata, resp_err);
    end
    tests++;
    if (req_ready !== 1'b0 || bus_read !== 1'b0) begin
      fails++;
      $display("FAIL lw_busy got rdy=%b r=%b exp 0 0",
               req_ready, bus_read);
    end
    step();
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL lw_idle got v=%b rdy=%b exp 0 1",
               resp_valid, req_ready);
    end
  endtask

  task automatic test_lb_lbu;
    mem[8'h40] = 32'h80FF_FFFF;
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    tests++;
    if (bus_byteen !== 4'h8 || bus_addr !== 32'h100) begin
      fails++;
      $display("FAIL lb_bus got be=%h a=%h exp 8 100",
               bus_byteen, bus_addr);
    end
    step();
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FF80) begin
      fails++;
      $display("FAIL lb_resp got v=%b d=%h exp 1 ffffff80",
               resp_valid, resp_rdata);
    end
    step();
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
    step();
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0080) begin
      fails++;
      $display("FAIL lbu_resp got v=%b d=%h exp 1 00000080",
               resp_valid, resp_rdata);
    end
    step();
  endtask

  task automatic test_split_store;
    mem[8'h80] = 32'h0;
    mem[8'h81] = 32'h0;
    issue(1'b1, 3'b010, 32'h0000_0202, 32'h1122_3344);
    tests++;
    if (bus_write !== 1'b1 || bus_read !== 1'b0
        || bus_addr !== 32'h200 || bus_byteen !== 4'hC) begin
      fails++;
      $display("FAIL sw1_bus got w=%b r=%b a=%h be=%h exp 1 0 200 c",
               bus_write, bus_read, bus_addr, bus_byteen);
    end
    tests++;
    if (bus_wdata !== 32'h3344_0000) begin
      fails++;
      $display("FAIL sw1_data got %h exp 33440000", bus_wdata);
    end
    step();
    tests++;
    if (bus_write !== 1'b1 || bus_addr !== 32'h204
        || bus_byteen !== 4'h3 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL sw2_bus got w=%b a=%h be=%h v=%b exp 1 204 3 0",
               bus_write, bus_addr, bus_byteen, resp_valid);
    end
    tests++;
    if (bus_wdata !== 32'h0000_1122 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL sw2_data got %h rdy=%b exp 00001122 0",
               bus_wdata, req_ready);
    end
    step();
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0
        || resp_err !== 1'b0 || bus_write !== 1'b0) begin
      fails++;
      $display("FAIL sw_resp got v=%b d=%h e=%b w=%b exp 1 0 0 0",
               resp_valid, resp_rdata, resp_err, bus_write);
    end
    tests++;
    if (mem[8'h80] !== 32'h3344_0000
        || mem[8'h81] !== 32'h0000_1122) begin
      fails++;
      $display("FAIL sw_mem got %h %h exp 33440000 00001122",
               mem[8'h80], mem[8'h81]);
    end
    step();
    issue(1'b0, 3'b010, 32'h0000_0202, 32'h0);
    step();
    tests++;
    if (bus_read !== 1'b1 || bus_addr !== 32'h204
        || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL lw_split_2nd got r=%b a=%h v=%b exp 1 204 0",
               bus_read, bus_addr, resp_valid);
    end
    step();
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h1122_3344) begin
      fails++;
      $display("FAIL lw_split got v=%b d=%h exp 1 11223344",
               resp_valid, resp_rdata);
    end
    step();
  endtask

  task automatic test_lh_wrap;
    mem[8'hFF] = 32'hAB00_0000;
    mem[8'h00] = 32'h0000_00C1;
    issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0);
    tests++;
    if (bus_addr !== 32'hFFFF_FFFC || bus_byteen !== 4'h8) begin
      fails++;
      $display("FAIL lh1_bus got a=%h be=%h exp fffffffc 8",
               bus_addr, bus_byteen);
    end
    step();
    tests++;
    if (bus_read !== 1'b1 || bus_addr !== 32'h0
        || bus_byteen !== 4'h1) begin
      fails++;
      $display("FAIL lh2_bus got r=%b a=%h be=%h exp 1 0 1",
               bus_read, bus_addr, bus_byteen);
    end
    step();
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_C1AB) begin
      fails++;
      $display("FAIL lh_wrap got v=%b d=%h exp 1 ffffc1ab",
               resp_valid, resp_rdata);
    end
    step();
  endtask

  task automatic test_illegal;
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
    tests++;
    if (bus_read !== 1'b0 || bus_write !== 1'b0) begin
      fails++;
      $display("FAIL ill_ld_bus got r=%b w=%b exp 0 0",
               bus_read, bus_write);
    end
    step();
    tests++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1
        || resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL ill_ld_resp got v=%b e=%b d=%h exp 1 1 0",
               resp_valid, resp_err, resp_rdata);
    end
    step();
    tests++;
    if (resp_err !== 1'b0) begin
      fails++;
      $display("FAIL ill_err_clr got %b exp 0", resp_err);
    end
    mem[8'h40] = 32'h1234_5678;
    issue(1'b1, 3'b100, 32'h0000_0100, 32'hAAAA_AAAA);
    tests++;
    if (bus_write !== 1'b0 || bus_read !== 1'b0) begin
      fails++;
      $display("FAIL ill_st_bus got r=%b w=%b exp 0 0",
               bus_read, bus_write);
    end
    step();
    tests++;
    if (resp_err !== 1'b1 || mem[8'h40] !== 32'h1234_5678) begin
      fails++;
      $display("FAIL ill_st_resp got e=%b m=%h exp 1 12345678",
               resp_err, mem[8'h40]);
    end
    step();
  endtask

  task automatic test_reset_mid;
    mem[8'h80] = 32'h0;
    mem[8'h81] = 32'h0;
    issue(1'b1, 3'b010, 32'h0000_0201, 32'hAABB_CCDD);
    tests++;
    if (bus_byteen !== 4'hE || bus_wdata !== 32'hBBCC_DD00) begin
      fails++;
      $display("FAIL rm1_bus got be=%h d=%h exp e bbccdd00",
               bus_byteen, bus_wdata);
    end
    step();
    tests++;
    if (bus_write !== 1'b1 || bus_byteen !== 4'h1) begin
      fails++;
      $display("FAIL rm2_bus got w=%b be=%h exp 1 1",
               bus_write, bus_byteen);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus_write !== 1'b0 || bus_byteen !== 4'h0
        || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rm_async got w=%b be=%h rdy=%b v=%b exp 0 0 1 0",
               bus_write, bus_byteen, req_ready, resp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (mem[8'h80] !== 32'hBBCC_DD00 || mem[8'h81] !== 32'h0) begin
      fails++;
      $display("FAIL rm_mem got %h %h exp bbccdd00 0",
               mem[8'h80], mem[8'h81]);
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rm_ready got %b exp 1", req_ready);
    end
    issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
    tests++;
    if (bus_read !== 1'b1 || bus_addr !== 32'h200) begin
      fails++;
      $display("FAIL rm_next_bus got r=%b a=%h exp 1 200",
               bus_read, bus_addr);
    end
    step();
    tests++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hBBCC_DD00) begin
      fails++;
      $display("FAIL rm_next got v=%b d=%h exp 1 bbccdd00",
               resp_valid, resp_rdata);
    end
    step();
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < 256; i++)
      mem[i] = 32'h0;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_split_store();
    test_lh_wrap();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
